// File: rtl/if_fetch_stage_pkg.sv
// Shared widths and helpers for the LoongArch instruction-fetch stage.
// Optional feature macro used by the stage: IF_ADEF_EN.
package if_fetch_stage_pkg;

    localparam int IF_TO_ID_LEN = 64;
    localparam int BR_BUS_LEN   = 34;

    typedef struct packed {
        logic [31:0] target;
        logic        taken;
        logic        taken_cancel;
    } br_bus_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry holding register for a fetched word that decode could not take yet.
module if_inst_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_inst,
    output logic        o_valid,
    output logic [31:0] o_inst
);

    logic        r_valid;
    logic [31:0] r_inst;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // NOTE: the data word carries no reset; r_valid alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (i_load && !i_flush) begin
            r_inst <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: next-PC selection, one outstanding SRAM fetch, redirect handling.
// Define IF_ADEF_EN to raise if_adef on misaligned fetch addresses instead of requesting.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [BR_BUS_LEN-1:0]   BR_BUS,
    input  logic                    ID_allowin,
    output logic                    IF_to_ID_valid,
    output logic [IF_TO_ID_LEN-1:0] IF_to_ID_BUS,
    output logic                    inst_sram_req,
    output logic [31:0]             inst_sram_addr,
    input  logic                    inst_sram_addr_ok,
    input  logic                    inst_sram_data_ok,
    input  logic [31:0]             inst_sram_rdata
`ifdef IF_ADEF_EN
    ,
    output logic                    if_adef
`endif
);

    br_bus_t     w_br;
    logic        w_cancel;
    logic        w_stall;
    logic [31:0] w_nextpc;
    logic        w_data_take;
    logic        w_ready_go;
    logic        w_allowin;
    logic        w_issue;
    logic        w_hs;
    logic        w_fire;
    logic        w_transfer;
    logic        w_ib_load;
    logic        w_ib_valid;
    logic [31:0] w_ib_inst;
    logic [31:0] w_if_inst;

    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic        r_waiting;
    logic        r_discard;
    logic        r_br_buf_valid;
    logic [31:0] r_br_buf_target;

    assign w_br     = br_bus_t'(BR_BUS);
    assign w_cancel = w_br.taken_cancel;
    assign w_stall  = w_br.taken & ~w_br.taken_cancel;

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        w_nextpc = r_if_pc + 32'd4;
        if (r_br_buf_valid) begin
            w_nextpc = r_br_buf_target;
        end else if (w_cancel) begin
            w_nextpc = w_br.target;
        end
    end

    assign w_data_take = r_waiting & inst_sram_data_ok & ~r_discard;
    assign w_issue     = resetn & w_allowin & ~r_discard & ~w_stall;
    assign w_hs        = inst_sram_req & inst_sram_addr_ok;
    assign inst_sram_addr = word_align(w_nextpc);

`ifdef IF_ADEF_EN
    logic r_adef;
    logic w_adef_fire;
    // A misaligned target never reaches the SRAM; it enters IF directly as a faulting slot.
    assign w_adef_fire   = w_issue & (|w_nextpc[1:0]);
    assign inst_sram_req = w_issue & ~(|w_nextpc[1:0]);
    assign w_fire        = w_hs | w_adef_fire;
    assign w_ready_go    = r_if_valid & (w_ib_valid | w_data_take | r_adef);
    assign w_if_inst     = r_adef ? 32'd0 : (w_ib_valid ? w_ib_inst : inst_sram_rdata);
    assign if_adef       = IF_to_ID_valid & r_adef;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_adef <= 1'b0;
        end else if (w_fire) begin
            r_adef <= w_adef_fire;
        end else if (w_cancel || w_allowin) begin
            r_adef <= 1'b0;
        end
    end
`else
    assign inst_sram_req = w_issue;
    assign w_fire        = w_hs;
    assign w_ready_go    = r_if_valid & (w_ib_valid | w_data_take);
    assign w_if_inst     = w_ib_valid ? w_ib_inst : inst_sram_rdata;
`endif

    assign w_allowin      = ~r_if_valid | (w_ready_go & ID_allowin);
    assign IF_to_ID_valid = w_ready_go & ~w_cancel;
    assign w_transfer     = IF_to_ID_valid & ID_allowin;
    assign w_ib_load      = w_data_take & ~ID_allowin & ~w_cancel;
    assign IF_to_ID_BUS   = IF_to_ID_valid ? {r_if_pc, w_if_inst} : '0;

    if_inst_buf u_inst_buf (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_ib_load),
        .i_flush (w_transfer | w_cancel),
        .i_inst  (inst_sram_rdata),
        .o_valid (w_ib_valid),
        .o_inst  (w_ib_inst)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_if_pc         <= RESET_PC - 32'd4;
            r_if_valid      <= 1'b0;
            r_waiting       <= 1'b0;
            r_discard       <= 1'b0;
            r_br_buf_valid  <= 1'b0;
            r_br_buf_target <= '0;
        end else begin
            if (w_fire) begin
                r_if_pc    <= w_nextpc;
                r_if_valid <= 1'b1;
            end else if (w_cancel || w_allowin) begin
                r_if_valid <= 1'b0;
            end

            if (w_hs) begin
                r_waiting <= 1'b1;
            end else if (r_waiting && inst_sram_data_ok) begin
                r_waiting <= 1'b0;
            end

            // The wrong-path word still in flight must be swallowed when it returns.
            if (w_cancel && r_waiting && !inst_sram_data_ok) begin
                r_discard <= 1'b1;
            end else if (r_discard && inst_sram_data_ok) begin
                r_discard <= 1'b0;
            end

            if (w_cancel && !(w_fire && !r_br_buf_valid)) begin
                r_br_buf_valid  <= 1'b1;
                r_br_buf_target <= w_br.target;
            end else if (w_fire) begin
                r_br_buf_valid <= 1'b0;
            end
        end
    end

endmodule
